// File: rtl/nes_controller_reader.sv
// nes_controller_reader
//   Polls a standard NES gamepad over its latch/pulse/data wires. The latest
//   8-bit button snapshot is returned to the CPU through a req/ack read port.
//
// Parameters
//   POLL_DIV  clock cycles between frame starts
//   HALF      clock cycles per half-period of latch/pulse
//
// Ports
//   clk        in   system clock, rising edge
//   nrst       in   asynchronous active-low reset
//   nes_data   in   serial data from pad, active-low (0 = pressed)
//   req        in   CPU read request for the button register
//   nes_latch  out  latch strobe to pad
//   nes_pulse  out  clock pulse to pad
//   nes_dout   out  {24'b0, buttons}; bit7=A ... bit0=Right, 1 = pressed
//   nes_ack    out  read acknowledge
//
// Build option
//   NES_DEBOUNCE_EN  when defined, a button bit only changes once two
//                    consecutive frames agree on it.
//
// State table
//   state      | meaning
//   S_IDLE     | waiting for poll trigger, latch/pulse low
//   S_LATCH    | latch high for 2*HALF cycles, A sampled on last cycle
//   S_PULSE_HI | pulse high for HALF cycles
//   S_PULSE_LO | pulse low for HALF cycles, next bit sampled on last cycle
//   S_COMMIT   | one cycle, shift register copied into buttons
module nes_controller_reader #(
  parameter int POLL_DIV = 166667,
  parameter int HALF     = 60
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        nes_data,
  input  logic        req,
  output logic        nes_latch,
  output logic        nes_pulse,
  output logic [31:0] nes_dout,
  output logic        nes_ack
);

  localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int HW = (2 * HALF > 1) ? $clog2(2 * HALF) : 1;
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_DIV - 1);
  localparam logic [HW-1:0] LATCH_LAST = HW'(2 * HALF - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_PULSE_HI,
    S_PULSE_LO,
    S_COMMIT
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [HW-1:0] phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sr_q, sr_d;
  logic [7:0]    buttons_q, buttons_d;
  logic [31:0]   dout_q, dout_d;
  logic          ack_q, ack_d;
  logic          trigger;
  logic          phase_last;
  logic [3:0]    bit_inc;   // bit[3] is the "8 bits received" flag
`ifdef NES_DEBOUNCE_EN
  logic [7:0]    raw_q, raw_d;
  logic [7:0]    agree;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      poll_q    <= '0;
      phase_q   <= '0;
      bit_q     <= '0;
      sr_q      <= '0;
      buttons_q <= '0;
      dout_q    <= '0;
      ack_q     <= 1'b0;
`ifdef NES_DEBOUNCE_EN
      raw_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      poll_q    <= poll_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      sr_q      <= sr_d;
      buttons_q <= buttons_d;
      dout_q    <= dout_d;
      ack_q     <= ack_d;
`ifdef NES_DEBOUNCE_EN
      raw_q     <= raw_d;
`endif
    end
  end

  // Free-running poll timer; trigger is its wrap cycle
  always_comb begin
    trigger = (poll_q == POLL_LAST);
    poll_d  = trigger ? '0 : poll_q + PW'(1);
  end

  always_comb begin
    phase_last = (state_q == S_LATCH) ? (phase_q == LATCH_LAST)
                                      : (phase_q == HALF_LAST);
    bit_inc    = {1'b0, bit_q} + 4'd1;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (trigger) state_d = S_LATCH;
      S_LATCH:    if (phase_last) state_d = S_PULSE_HI;
      S_PULSE_HI: if (phase_last) state_d = S_PULSE_LO;
      S_PULSE_LO: if (phase_last) state_d = bit_inc[3] ? S_COMMIT : S_PULSE_HI;
      S_COMMIT:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Phase/bit counters, shift register and button snapshot
  always_comb begin
    phase_d   = (state_q == S_IDLE || state_q == S_COMMIT || phase_last)
                ? '0 : phase_q + HW'(1);
    bit_d     = bit_q;
    sr_d      = sr_q;
    buttons_d = buttons_q;
`ifdef NES_DEBOUNCE_EN
    raw_d     = raw_q;
    agree     = ~(sr_q ^ raw_q);
`endif
    case (state_q)
      S_IDLE: if (trigger) bit_d = '0;
      S_LATCH: begin
        if (phase_last) begin
          sr_d  = {sr_q[6:0], ~nes_data};
          bit_d = 3'd1;
        end
      end
      S_PULSE_LO: begin
        if (phase_last) begin
          sr_d  = {sr_q[6:0], ~nes_data};
          bit_d = bit_inc[2:0];
        end
      end
      S_COMMIT: begin
`ifdef NES_DEBOUNCE_EN
        // Bits that disagree with the previous raw frame hold their value
        buttons_d = (sr_q & agree) | (buttons_q & ~agree);
        raw_d     = sr_q;
`else
        buttons_d = sr_q;
`endif
      end
      default: ;
    endcase
  end

  // Read handshake: capture once per request, frozen while req stays high
  always_comb begin
    dout_d = dout_q;
    ack_d  = ack_q;
    if (req && !ack_q) begin
      dout_d = {24'b0, buttons_q};
      ack_d  = 1'b1;
    end else if (!req) begin
      ack_d  = 1'b0;
    end
  end

  // Outputs decoded from state so reset drops them immediately
  always_comb begin
    nes_latch = (state_q == S_LATCH);
    nes_pulse = (state_q == S_PULSE_HI);
    nes_dout  = dout_q;
    nes_ack   = ack_q;
  end

endmodule
